// File: rtl/perceptron_learner.sv
// Online perceptron classifying 4x4 bit patterns as O or X.
// Scores one grid row per cycle and learns from misclassified training samples.
module perceptron_learner #(
  parameter int LR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] train_x,
  input  logic        train_learn,
  input  logic        train_is_O,
  input  logic [15:0] infer_x,
  input  logic        infer_start,
  input  logic        clear_w,
  output logic        busy,
  output logic        pred_valid,
  output logic        pred_is_O,
  output logic [12:0] pred_score,
  output logic [15:0] sample_cnt,
  output logic [15:0] err_cnt,
  output logic [1:0]  dbg_state
);

  // Handshake: infer_start is a one-cycle request with no ready; a request that
  // arrives while busy waits in a one-deep slot, and pred_valid pulses once per
  // served inference with no backpressure.
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EVAL, S_UPDATE} state_t;

  localparam logic signed [8:0] SAT_MAX = 9'sd127;
  localparam logic signed [8:0] SAT_MIN = -9'sd128;

  state_t      r_state, w_next_state;
  logic [7:0]  r_w [16];
  logic [7:0]  r_bias;
  logic [12:0] r_acc;
  logic [1:0]  r_row;
  logic [15:0] r_pat;
  logic        r_lbl, r_is_learn;
  logic        r_prev_learn, r_prev_lbl;
  logic [15:0] r_prev_x;
  logic        r_pend_learn, r_pend_lbl, r_pend_inf;
  logic [15:0] r_pend_x, r_pend_ix;
  logic        r_pred_valid, r_pred_o;
  logic [12:0] r_pred_score;
  logic [15:0] r_sample_cnt, r_err_cnt;

  logic        w_learn_evt, w_take_learn, w_take_infer, w_pred_o;
  logic [12:0] w_row_sum;
  logic [7:0]  w_w_upd [16];
  logic [7:0]  w_bias_upd;

  function automatic logic [7:0] sat_step(input logic [7:0] w, input logic up);
    logic signed [8:0] s;
    s = up ? ($signed({w[7], w}) + $signed(9'(LR))) : ($signed({w[7], w}) - $signed(9'(LR)));
    if (s > SAT_MAX) return 8'h7F;
    else if (s < SAT_MIN) return 8'h80;
    else return s[7:0];
  endfunction

  assign w_learn_evt  = train_learn && (!r_prev_learn || (train_x != r_prev_x) || (train_is_O != r_prev_lbl));
  assign w_take_learn = (r_state == S_IDLE) && !clear_w && (w_learn_evt || r_pend_learn);
  assign w_take_infer = (r_state == S_IDLE) && !clear_w && !w_take_learn && (infer_start || r_pend_inf);
  assign w_pred_o     = !r_acc[12];

  // Row r occupies bits [15-4r : 12-4r], i.e. base index {~r, 2'b00}.
  always_comb begin
    w_row_sum = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_pat[{~r_row, 2'(k)}])
        w_row_sum = w_row_sum + {{5{r_w[{~r_row, 2'(k)}][7]}}, r_w[{~r_row, 2'(k)}]};
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++)
      w_w_upd[i] = r_pat[i] ? sat_step(r_w[i], r_lbl) : r_w[i];
    w_bias_upd = sat_step(r_bias, r_lbl);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_take_learn || w_take_infer) w_next_state = S_ACCUM;
      S_ACCUM:  if (r_row == 2'd3) w_next_state = S_EVAL;
      S_EVAL:   w_next_state = (r_is_learn && (w_pred_o != r_lbl)) ? S_UPDATE : S_IDLE;
      S_UPDATE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_bias       <= '0;
      r_acc        <= '0;
      r_row        <= '0;
      r_pat        <= '0;
      r_lbl        <= 1'b0;
      r_is_learn   <= 1'b0;
      r_prev_learn <= 1'b0;
      r_prev_lbl   <= 1'b0;
      r_prev_x     <= '0;
      r_pend_learn <= 1'b0;
      r_pend_lbl   <= 1'b0;
      r_pend_x     <= '0;
      r_pend_inf   <= 1'b0;
      r_pend_ix    <= '0;
      r_pred_valid <= 1'b0;
      r_pred_o     <= 1'b0;
      r_pred_score <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_prev_learn <= train_learn;
      r_prev_x     <= train_x;
      r_prev_lbl   <= train_is_O;
      r_pred_valid <= 1'b0;

      // A served request also retires any older pending one of the same type.
      if (w_learn_evt && !w_take_learn) begin
        r_pend_learn <= 1'b1;
        r_pend_x     <= train_x;
        r_pend_lbl   <= train_is_O;
      end else if (w_take_learn) begin
        r_pend_learn <= 1'b0;
      end
      if (infer_start && !w_take_infer) begin
        r_pend_inf <= 1'b1;
        r_pend_ix  <= infer_x;
      end else if (w_take_infer) begin
        r_pend_inf <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (clear_w) begin
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            r_bias <= '0;
          end
          if (w_take_learn || w_take_infer) begin
            r_acc <= {{5{r_bias[7]}}, r_bias};
            r_row <= '0;
          end
          if (w_take_learn) begin
            r_pat      <= w_learn_evt ? train_x : r_pend_x;
            r_lbl      <= w_learn_evt ? train_is_O : r_pend_lbl;
            r_is_learn <= 1'b1;
          end else if (w_take_infer) begin
            r_pat      <= infer_start ? infer_x : r_pend_ix;
            r_is_learn <= 1'b0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_row_sum;
          r_row <= r_row + 2'd1;
        end
        S_EVAL: begin
          if (r_is_learn) begin
            if (r_sample_cnt != 16'hFFFF) r_sample_cnt <= r_sample_cnt + 16'd1;
          end else begin
            r_pred_valid <= 1'b1;
            r_pred_o     <= w_pred_o;
            r_pred_score <= r_acc;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < 16; i++) r_w[i] <= w_w_upd[i];
          r_bias <= w_bias_upd;
          if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign pred_valid = r_pred_valid;
  assign pred_is_O  = r_pred_o;
  assign pred_score = r_pred_score;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign dbg_state  = r_state;

endmodule

// File: doc/perceptron_learner.md
PERCEPTRON_LEARNER -- requirements
Module: perceptron_learner

Interface
REQ-001 Parameter LR, default 1: signed weight/bias step per update, range 1..127.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 train_x  in  16  training pattern, 4x4 grid, bit 15 = top-left, row r = bits [15-4r : 12-4r].
REQ-005 train_learn  in  1  training sample present; held high for several cycles per sample.
REQ-006 train_is_O  in  1  label for train_x: 1 = O, 0 = X.
REQ-007 infer_x  in  16  pattern to classify.
REQ-008 infer_start  in  1  single-cycle inference request.
REQ-009 clear_w  in  1  synchronous clear of all weights and bias.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 pred_valid  out  1  one-cycle pulse when an inference result is ready.
REQ-012 pred_is_O  out  1  inference result, 1 = O; held until the next inference.
REQ-013 pred_score  out  13  signed score of the last inference; held.
REQ-014 sample_cnt  out  16  learn samples processed; saturates at 16'hFFFF.
REQ-015 err_cnt  out  16  learn samples that caused an update; saturates at 16'hFFFF.

Function
REQ-016 Storage: 16 signed 8-bit weights w[0..15] (w[i] pairs with bit i) and one signed 8-bit bias.
REQ-017 Learn event: in the cycle where train_learn=1 and (train_learn was 0 last cycle, or train_x differs from last cycle, or train_is_O differs from last cycle).
- A sample held constant for any number of cycles produces exactly one event.
- Identical back-to-back samples without train_learn going low merge into one event.
REQ-018 FSM states: IDLE, ACCUM, EVAL, UPDATE.
REQ-019 IDLE: on a learn event or pending learn, latch pattern and label, set acc = sign-extended bias and row = 0, and go to ACCUM.
- Otherwise, on infer_start or pending inference, latch infer_x in the same way and go to ACCUM.
- Learn has priority over inference.
REQ-020 ACCUM: each cycle, add the weights of the set bits in latched row "row" to acc, then increment row.
- After row 3, go to EVAL; ACCUM always lasts exactly 4 cycles.
REQ-021 acc is 13-bit signed and cannot overflow; prediction = O when acc >= 0, else X.
REQ-022 EVAL for an inference: update pred_is_O and pred_score, pulse pred_valid, go to IDLE.
- pred_valid is high in the 6th cycle after the infer_start edge, counting that edge as cycle 0.
REQ-023 EVAL for a learn: increment sample_cnt.
- If prediction equals the label, go to IDLE.
- Otherwise go to UPDATE.
REQ-024 UPDATE: in one cycle, for every set bit i, w[i] += LR if the label is O, w[i] -= LR if the label is X; apply the same to bias.
- Results saturate to [-128, +127].
- Increment err_cnt, then go to IDLE.
REQ-025 A learn event or infer_start arriving while busy is stored in a one-deep pending slot per type; a newer request of the same type overwrites it.
- The pending slot is served on return to IDLE.
REQ-026 A complete learn takes 6 cycles (≤ 11-cycle sample spacing), so no sample from a 10-cycle-hold source is lost.
REQ-027 clear_w is honoured only in IDLE: zero all weights and bias; counters unaffected.
- If a learn event or infer_start coincides with clear_w, clear first and service the request on the next cycle.
REQ-028 pred_is_O and pred_score never change during learning.

Reset
REQ-029 rst_n low, at any time including mid-ACCUM or mid-UPDATE, immediately sets:
- FSM to IDLE; weights, bias, acc and row to 0; pending slots and edge-detect history to 0.
- busy=0, pred_valid=0, pred_is_O=0, pred_score=0, sample_cnt=0, err_cnt=0.
REQ-030 An update interrupted by reset is discarded in full; no partial weight change survives.

Verification
REQ-031 After reset, infer_start with infer_x=16'hF99F -> busy for 5 cycles, pred_valid at cycle 6, pred_score=0, pred_is_O=1.
REQ-032 Learn 16'h9669 with label X held 10 cycles -> one event; the 8 weights on set bits become -1 and bias -1; sample_cnt=1, err_cnt=1; then infer 16'h9669 -> pred_score=-9, pred_is_O=0.
REQ-033 Same sample presented twice with train_learn low for one cycle between -> sample_cnt=2, err_cnt=1 (second is correct).
REQ-034 infer_start in the 2nd ACCUM cycle of a learn -> learn completes, then the inference runs, with its pred_valid at most 11 cycles after the request.
REQ-035 rst_n asserted in the 3rd ACCUM cycle of a mismatching learn -> all outputs 0 and all weights 0; a following inference gives pred_score=0.
REQ-036 LR=100: learn X 16'h0001 -> w[0]=-100, bias=-100; a second identical learn after a train_learn low cycle -> no update, err_cnt=1.
